// File: rtl/sp_shift_receiver.sv
// Receive side of the LED-matrix serial link: oversamples sp_clk/sp_dat/sp_ratch,
// rebuilds each frame, length-checks it and files good frames into an 8-row buffer.

module sp_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ff <= '0;
    else          ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

module sp_shift_receiver #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sp_clk,
  input  logic                           sp_dat,
  input  logic                           sp_ratch,
  input  logic [2:0]                     ledm_sel,
  output logic [WIDTH-1:0]               par_out,
  output logic [2:0]                     frame_sel,
  output logic                           frame_valid,
  output logic                           frame_err,
  output logic [7:0]                     err_cnt,
  output logic [$clog2(WIDTH+2)-1:0]     bit_cnt,
  input  logic [2:0]                     rd_addr,
  output logic [WIDTH-1:0]               rd_data
);
  localparam int CW = $clog2(WIDTH+2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

  logic [5:0]       raw, syncd;
  logic             s_clk, s_dat, s_lat;
  logic [2:0]       s_sel;
  logic             clk_d, lat_d, rise_clk, rise_lat;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             len_ok;
  state_t           state;
  logic [WIDTH-1:0] row_mem [8];

  // One synchronizer per input wire, all with identical depth so data stays aligned to sp_clk.
  assign raw = {ledm_sel, sp_ratch, sp_dat, sp_clk};
  sp_sync_bit #(.STAGES(SYNC_STAGES)) u_sync [5:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (raw),
    .q       (syncd)
  );
  assign s_clk = syncd[0];
  assign s_dat = syncd[1];
  assign s_lat = syncd[2];
  assign s_sel = syncd[5:3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_d <= 1'b0;
      lat_d <= 1'b0;
    end else begin
      clk_d <= s_clk;
      lat_d <= s_lat;
    end
  end

  assign rise_clk = s_clk & ~clk_d;
  assign rise_lat = s_lat & ~lat_d;

  always_comb begin
    state = IDLE;
    if (bit_cnt == '0)           state = IDLE;
    else if (bit_cnt < CNT_FULL) state = SHIFT;
    else if (bit_cnt == CNT_FULL) state = FULL;
    else                         state = OVER;
  end

  // Shift is resolved before the latch so a coincident sp_clk rise lands in the frame.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    if (rise_clk) begin
      shreg_nxt = {shreg[WIDTH-2:0], s_dat};
      if (state != OVER) cnt_nxt = bit_cnt + 1'b1;
    end
  end

  assign len_ok = (cnt_nxt == CNT_FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      par_out     <= '0;
      frame_sel   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
      for (int i = 0; i < 8; i++) row_mem[i] <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      shreg       <= shreg_nxt;
      bit_cnt     <= rise_lat ? '0 : cnt_nxt;
      if (rise_lat) begin
        par_out   <= shreg_nxt;
        frame_sel <= s_sel;
        if (len_ok) begin
          row_mem[s_sel] <= shreg_nxt;
          frame_valid    <= 1'b1;
        end else begin
          frame_err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  assign rd_data = row_mem[rd_addr];
endmodule

// File: tb/tb_sp_shift_receiver.sv
// Bench for sp_shift_receiver: pin-level frame model delayed by the sync latency,
// compared every cycle, plus literal checks on the directed frames.

module tb_sp_shift_receiver;
  localparam int W  = 16;
  localparam int SS = 2;
  localparam int CW = $clog2(W+2);

  logic           clk, reset_n, sp_clk, sp_dat, sp_ratch;
  logic [2:0]     ledm_sel, frame_sel, rd_addr;
  logic [W-1:0]   par_out, rd_data;
  logic           frame_valid, frame_err;
  logic [7:0]     err_cnt;
  logic [CW-1:0]  bit_cnt;

  int checks   = 0;
  int failures = 0;

  sp_shift_receiver #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .sp_clk(sp_clk), .sp_dat(sp_dat),
    .sp_ratch(sp_ratch), .ledm_sel(ledm_sel), .par_out(par_out),
    .frame_sel(frame_sel), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_cnt(err_cnt), .bit_cnt(bit_cnt), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected observable state as a frame-level summary of what the pins have done.
  typedef struct packed {
    logic [7:0][W-1:0] rows;
    logic [W-1:0]      par;
    logic [2:0]        sel;
    logic              v;
    logic              e;
    logic [7:0]        ecnt;
    logic [CW-1:0]     bcnt;
  } mst_t;

  mst_t         m;
  mst_t         pipe [SS+1];
  logic [W-1:0] hist;
  int           cnt;
  logic         pclk, plat;

  always @(posedge clk) begin
    if (!reset_n) begin
      m = '0; hist = '0; cnt = 0; pclk = 1'b0; plat = 1'b0;
      for (int i = 0; i <= SS; i++) pipe[i] = '0;
    end else begin
      m.v = 1'b0;
      m.e = 1'b0;
      if (sp_clk && !pclk) begin
        hist = {hist[W-2:0], sp_dat};
        if (cnt < W + 1) cnt = cnt + 1;
      end
      if (sp_ratch && !plat) begin
        m.par = hist;
        m.sel = ledm_sel;
        if (cnt == W) begin
          m.rows[ledm_sel] = hist;
          m.v = 1'b1;
        end else begin
          m.e = 1'b1;
          if (m.ecnt != 8'hFF) m.ecnt = m.ecnt + 8'd1;
        end
        cnt = 0;
      end
      m.bcnt = CW'(cnt);
      pclk = sp_clk;
      plat = sp_ratch;
      for (int i = SS; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = m;
    end
  end

  always @(negedge clk) begin
    mst_t x;
    if (!reset_n) x = '0;
    else          x = pipe[SS];
    chk("par_out",     32'(par_out),     32'(x.par));
    chk("frame_sel",   32'(frame_sel),   32'(x.sel));
    chk("frame_valid", 32'(frame_valid), 32'(x.v));
    chk("frame_err",   32'(frame_err),   32'(x.e));
    chk("err_cnt",     32'(err_cnt),     32'(x.ecnt));
    chk("bit_cnt",     32'(bit_cnt),     32'(x.bcnt));
    chk("rd_data",     32'(rd_data),     32'(x.rows[rd_addr]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rd_addr = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit rnd);
    for (int i = n - 1; i >= 0; i--) begin
      sp_dat = v[i];
      wait_n(rnd ? $urandom_range(2, 4) : 4);
      sp_clk = 1'b1;
      wait_n(rnd ? $urandom_range(2, 4) : 4);
      sp_clk = 1'b0;
    end
  endtask

  task automatic wait_flag(input string name);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (frame_valid || frame_err) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic latch_start(input logic [2:0] sel, input string name);
    ledm_sel = sel;
    wait_n(2);
    sp_ratch = 1'b1;
    wait_flag(name);
  endtask

  task automatic latch_end(input string name);
    tick();
    chk({name, "_pulse_len"}, 32'(frame_valid | frame_err), 32'd0);
    sp_ratch = 1'b0;
    wait_n(3);
  endtask

  task automatic read_row(input logic [2:0] a, input logic [W-1:0] exp, input string name);
    rd_addr = a;
    #1;
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b0; sp_clk = 1'b0; sp_dat = 1'b0; sp_ratch = 1'b0;
    ledm_sel = '0; rd_addr = '0;
    #100;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_n(4);
    for (int i = 0; i < 8; i++) read_row(3'(i), '0, "reset_rd");
    chk("reset_par", 32'(par_out), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);

    // Good frame
    send_bits(32'hA5C3, 16, 0);
    latch_start(3'd3, "good");
    chk("good_valid", 32'(frame_valid), 32'd1);
    chk("good_par", 32'(par_out), 32'hA5C3);
    chk("good_sel", 32'(frame_sel), 32'd3);
    read_row(3'd3, 16'hA5C3, "good_row3");
    latch_end("good");
    for (int i = 0; i < 8; i++) if (i != 3) read_row(3'(i), '0, "good_other_rows");

    // Short frame
    send_bits(32'h1357, 15, 0);
    latch_start(3'd5, "short");
    chk("short_err", 32'(frame_err), 32'd1);
    chk("short_err_cnt", 32'(err_cnt), 32'd1);
    read_row(3'd5, '0, "short_row5");
    latch_end("short");
    chk("short_bit_cnt", 32'(bit_cnt), 32'd0);

    // Long frame: two extra leading bits then 16'h1234
    send_bits(32'h2_1234, 18, 0);
    latch_start(3'd6, "long");
    chk("long_err", 32'(frame_err), 32'd1);
    chk("long_par", 32'(par_out), 32'h1234);
    chk("long_err_cnt", 32'(err_cnt), 32'd2);
    read_row(3'd6, '0, "long_row6");
    read_row(3'd3, 16'hA5C3, "long_row3");
    latch_end("long");

    // 16th sp_clk rise coincident with sp_ratch rise
    send_bits(32'h4000, 15, 0);
    sp_dat = 1'b1;
    ledm_sel = 3'd1;
    wait_n(4);
    sp_clk = 1'b1;
    sp_ratch = 1'b1;
    wait_flag("simul");
    chk("simul_valid", 32'(frame_valid), 32'd1);
    chk("simul_par", 32'(par_out), 32'h8001);
    read_row(3'd1, 16'h8001, "simul_row1");
    tick();
    chk("simul_pulse_len", 32'(frame_valid | frame_err), 32'd0);
    sp_clk = 1'b0;
    sp_ratch = 1'b0;
    wait_n(3);

    // Reset in the middle of a frame
    send_bits(32'h7F, 7, 0);
    wait_n(3);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_bit_cnt", 32'(bit_cnt), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_n(3);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    send_bits(32'hFFFF, 16, 0);
    latch_start(3'd0, "midrst");
    chk("midrst_valid", 32'(frame_valid), 32'd1);
    read_row(3'd0, 16'hFFFF, "midrst_row0");
    read_row(3'd1, '0, "midrst_row1");
    latch_end("midrst");

    // Random frames with random lengths and phase timing
    for (int f = 0; f < 30; f++) begin
      int len;
      case ($urandom_range(0, 3))
        0, 1:    len = W;
        2:       len = W - 1 - $urandom_range(0, 2);
        default: len = W + 1 + $urandom_range(0, 1);
      endcase
      send_bits($urandom, len, 1);
      latch_start(3'($urandom_range(0, 7)), "rand");
      latch_end("rand");
    end

    // Empty frames drive err_cnt into saturation
    for (int f = 0; f < 260; f++) begin
      ledm_sel = 3'($urandom_range(0, 7));
      wait_n(2);
      sp_ratch = 1'b1;
      wait_n(2);
      sp_ratch = 1'b0;
      wait_n(2);
    end
    wait_n(4);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sp_shift_receiver.md
# sp_shift_receiver

Receive-side model of the LED-matrix serial link: it recovers the frames that the blink controller shifts out on `sp_clk`/`sp_dat`/`sp_ratch`. All three lines, plus the `ledm_sel` row select, are oversampled in the system clock domain. Each latched word is stored into an 8-entry row buffer indexed by the captured row select. The block serves as the synthesizable checker and loopback target for the LED driver, on the board and in simulation.

## Interface
- `WIDTH`, 16: bits per serial frame (≥2).
- `SYNC_STAGES`, 2: synchronizer depth on the serial inputs (≥2).
- `clk`  in  1: system clock (50 MHz board clock).
- `reset_n`  in  1: reset, asynchronous assert, active-low.
- `sp_clk`  in  1: serial shift clock; data is sampled on its rising edge.
- `sp_dat`  in  1: serial data, MSB first.
- `sp_ratch`  in  1: latch strobe; its rising edge ends the frame.
- `ledm_sel`  in  3: row select; sampled at the latch event.
- `par_out`  out  WIDTH: last latched word.
- `frame_sel`  out  3: `ledm_sel` value captured with `par_out`.
- `frame_valid`  out  1: one-cycle pulse when a frame with the correct length is latched.
- `frame_err`  out  1: one-cycle pulse when a frame with the wrong length (short or long) is latched.
- `err_cnt`  out  8: saturating count of `frame_err` pulses.
- `bit_cnt`  out  $clog2(WIDTH+2): bits shifted since the last latch.
- `rd_addr`  in  3: row buffer read address.
- `rd_data`  out  WIDTH: row buffer contents, read combinationally.

## Operation
- **Input synchronization.** `sp_clk`, `sp_dat`, `sp_ratch` and `ledm_sel` each pass through a `SYNC_STAGES` flop chain. A further flop delays the synchronized `sp_clk` and `sp_ratch`.
- **Edge detection.**
  - `rise_clk` = synchronized `sp_clk` AND NOT its delayed copy.
  - `rise_lat` = the same construction on `sp_ratch`.
- **Shift.** On each `rise_clk`: `shreg <= {shreg[WIDTH-2:0], sync_dat}`, and `bit_cnt` increments, saturating at WIDTH+1.
- **State (derived from `bit_cnt`):**
  - IDLE: `bit_cnt` = 0.
  - SHIFT: 0 < `bit_cnt` < WIDTH.
  - FULL: `bit_cnt` = WIDTH.
  - OVER: `bit_cnt` = WIDTH+1 (saturated).
  - Transitions are IDLE→SHIFT→FULL→OVER on `rise_clk`. Any state returns to IDLE on `rise_lat`.
- **Latch event (`rise_lat`):**
  - `par_out` takes the post-shift `shreg`.
  - `frame_sel` takes the synchronized `ledm_sel`.
  - If `bit_cnt` (including a simultaneous `rise_clk`) equals WIDTH:
    - `row_mem[frame_sel] <= shreg`;
    - pulse `frame_valid`.
  - Otherwise:
    - pulse `frame_err`;
    - `err_cnt` increments, saturating at 255;
    - `row_mem` is unchanged.
  - `bit_cnt` is cleared to 0 after the event.
  - `shreg` is not cleared.
- **Simultaneous events.** When `rise_clk` and `rise_lat` occur in the same cycle, the shift is applied first. The latch captures the new bit, and that bit counts toward the length check.
- **Long frames.** In OVER, further `rise_clk` events keep shifting; only the newest WIDTH bits are retained.
- **Read port.** `rd_data` = `row_mem[rd_addr]`; there is no read latency.
- **Reset (`reset_n` low, asynchronous):**
  - all synchronizer and edge flops, `shreg`, `bit_cnt`, `par_out`, `frame_sel`, `frame_valid`, `frame_err`, `err_cnt` and all 8 `row_mem` entries go to 0;
  - `rd_data` therefore reads 0 for every address.
- **Reset mid-frame.** A partial frame is discarded; no flags are raised on reset release.
- **Release.** Delayed copies reset to 0, so a line already high when reset is released produces one rise on the first synchronized cycle. The bench must hold `sp_clk`/`sp_ratch` low across reset release.

## Timing
- **Pin-to-shift latency.** A pin edge meeting setup before `clk` edge N asserts `rise_clk` during cycle N+`SYNC_STAGES`−1. `shreg`/`bit_cnt` update at edge N+`SYNC_STAGES` (edge N+2 at the default).
- **Pin-to-latch latency.** The latch path has the same latency. `par_out`, `frame_sel`, `row_mem`, `frame_valid` and `frame_err` update at edge N+`SYNC_STAGES`. The pulses last exactly one `clk` cycle.
- **Data sampling.** `sp_dat` is delayed by the same `SYNC_STAGES`, so it is sampled aligned with `sp_clk`.
- **Sender requirements.**
  - `sp_dat` stable ≥1 `clk` period before and after each `sp_clk` rise.
  - Every high and low phase of `sp_clk`/`sp_ratch` lasts ≥2 `clk` periods.
  - `ledm_sel` stable ≥1 `clk` period around each `sp_ratch` rise.
- **Throughput.** Minimum `sp_clk` period is 4 `clk` cycles. There is no backpressure.

## Test plan
- **Reset.** Assert `reset_n` low for 100 ns, release with serial lines low. Required: all outputs 0, `rd_data` 0 for `rd_addr` 0–7, and no `frame_valid`/`frame_err` pulse.
- **Good frame.**
  - Stimulus: shift 16'hA5C3 MSB first, 8 `clk` per bit, `ledm_sel`=3, then pulse `sp_ratch`.
  - Required, 2 cycles after the latch rise: `par_out`=16'hA5C3, `frame_sel`=3, one-cycle `frame_valid`, and `rd_data`@3 = 16'hA5C3.
  - Required: other rows stay 0.
- **Short frame.** Shift 15 bits, then latch with `ledm_sel`=5. Required: `frame_err` pulse, `err_cnt`=1, `rd_data`@5 = 0, and `bit_cnt` returns to 0.
- **Long frame.** Shift 18 bits ending in 16'h1234, then latch. Required: `par_out`=16'h1234, `frame_err` pulse, `err_cnt` increments, and `row_mem` unchanged.
- **Simultaneous edges.** Make the 16th `sp_clk` rise and the `sp_ratch` rise in the same `clk` cycle. Required: the frame is accepted (`frame_valid`), with the 16th bit included in `par_out`.
- **Mid-frame reset.**
  - Stimulus: assert `reset_n` after 7 bits, release, then send a full 16'hFFFF frame to row 0.
  - Required: `bit_cnt` clears asynchronously, and the frame after release is accepted with `rd_data`@0 = 16'hFFFF.
  - Additionally: after 260 error frames, `err_cnt` holds at 255.
